// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, followed by a single sign-fixup cycle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic              sa, sb, spec;
  logic [XLEN-1:0]   spec_val;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN:0]     rem;

  logic              can_accept;
  logic              a_sgn, b_sgn, spec_hit;
  logic [XLEN-1:0]   ma, mb, spec_n;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_wide;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_fix;

  assign can_accept = (state == IDLE || state == DONE) && start && !flush;

  // Operand signedness, magnitudes and special-case detection at accept.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin a_sgn = a[XLEN-1]; b_sgn = b[XLEN-1]; end
      3'b010:                 a_sgn = a[XLEN-1];
      default: ;
    endcase
    ma       = a_sgn ? -a : a;
    mb       = b_sgn ? -b : b;
    spec_hit = 1'b0;
    spec_n   = '0;
    if (funct3[2] && b == '0) begin
      spec_hit = 1'b1;
      spec_n   = funct3[1] ? a : '1;
    end else if (funct3[2] && !funct3[0] && a == MOST_NEG && b == '1) begin
      spec_hit = 1'b1;
      spec_n   = funct3[1] ? '0 : MOST_NEG;
    end
  end

  // One iteration of each datapath; the divide keeps one spare top bit so the
  // shifted partial remainder never overflows before the compare.
  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opb} : '0);
    div_wide = {rem, quo[XLEN-1]};
    div_ge   = div_wide >= {2'b00, opb};
  end

  always_comb begin
    prod_fix = (sa ^ sb) ? -prod : prod;
    quo_fix  = (sa ^ sb) ? -quo : quo;
    rem_fix  = sa ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    res_fix  = '0;
    if (spec) begin
      res_fix = spec_val;
    end else begin
      case (op)
        3'b000:                 res_fix = prod_fix[XLEN-1:0];
        3'b001, 3'b010, 3'b011: res_fix = prod_fix[2*XLEN-1:XLEN];
        3'b100, 3'b101:         res_fix = quo_fix;
        default:                res_fix = rem_fix;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cnt      <= '0;
      op       <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      spec     <= 1'b0;
      spec_val <= '0;
      opb      <= '0;
      prod     <= '0;
      quo      <= '0;
      rem      <= '0;
    end else begin
      done <= 1'b0;
      if (can_accept) begin
        op       <= funct3;
        sa       <= a_sgn;
        sb       <= b_sgn;
        spec     <= spec_hit;
        spec_val <= spec_n;
        opb      <= mb;
        prod     <= {{XLEN{1'b0}}, ma};
        quo      <= ma;
        rem      <= '0;
        cnt      <= '0;
        busy     <= 1'b1;
        state    <= spec_hit ? SIGN : CALC;
      end else begin
        case (state)
          CALC: begin
            if (flush) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              if (op[2]) begin
                rem <= div_ge ? (XLEN+1)'(div_wide - {2'b00, opb}) : div_wide[XLEN:0];
                quo <= {quo[XLEN-2:0], div_ge};
              end else begin
                prod <= {mul_sum, prod[XLEN-1:1]};
              end
              cnt <= cnt + 1'b1;
              if (cnt == CNT_W'(XLEN - 1)) state <= SIGN;
            end
          end
          SIGN: begin
            busy  <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              result <= res_fix;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
